gain_scheduler: RTL and testbench
=================================

Name: gain_scheduler

Overview:
- Stereo gain controller. One gain multiply/dequantize datapath is shared between the left and right audio channels.
- Round-robin arbitration between the two input FIFOs. Each grant is sequenced through a read, multiply and write pipeline.
- Holds a volume register that ramps toward a target set by software, which gives soft start and zipper-free volume changes.
- Sits at the end of the demodulation chain, between the L/R deemphasis output FIFOs and the audio output FIFOs.

Parameters:
DATA_SIZE, 32, sample and volume width (signed, fixed point)
BITS, 10, fractional bits of the quantized format
RAMP_STEP, 64, maximum change of the current volume per ramp update (quantized units)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
l_in_empty  in  1  left input FIFO empty
l_in_rd_en  out  1  left input FIFO pop
l_din  in  DATA_SIZE  left sample, signed, valid while l_in_empty=0 (first-word fall-through)
r_in_empty  in  1  right input FIFO empty
r_in_rd_en  out  1  right input FIFO pop
r_din  in  DATA_SIZE  right sample, signed
l_out_full  in  1  left output FIFO full
l_out_wr_en  out  1  left output FIFO push
l_dout  out  DATA_SIZE  left scaled sample, signed
r_out_full  in  1  right output FIFO full
r_out_wr_en  out  1  right output FIFO push
r_dout  out  DATA_SIZE  right scaled sample, signed
vol_target  in  DATA_SIZE  target volume, signed quantized (1.0 = 2^BITS); sampled every cycle
vol_cur  out  DATA_SIZE  current applied volume (status)

Behaviour:
- Reset (async):
  - state=ARB, rr_ptr=L, vol_cur=0, sample/product/chan registers=0.
  - All rd_en and wr_en outputs = 0; l_dout = r_dout = 0.
- Reset mid-operation: any in-flight sample is discarded. No wr_en is asserted for it.
- Clean-state defaults: rd_en and wr_en are 0 in every state except where stated below.
- Eligibility:
  - L is eligible when !l_in_empty && !l_out_full.
  - R is eligible when !r_in_empty && !r_out_full.
- ARB:
  - If the rr_ptr channel is eligible, grant it. Otherwise grant the other channel if it is eligible. Otherwise stay in ARB.
  - On a grant, the same cycle: assert that channel's rd_en for exactly 1 cycle, capture its din into the sample register, record chan, set rr_ptr = the other channel, go to MULT.
  - Only one rd_en may be high in any cycle.
- MULT:
  - product (2*DATA_SIZE, signed) <= sample * vol_cur. Go to WRITE.
- WRITE:
  - If the chan output is not full: assert that wr_en for 1 cycle, drive that dout = result, go to ARB.
  - Otherwise hold in WRITE with wr_en=0 and no data loss.
  - The other channel's dout holds its last value.
- Arithmetic:
  - result = (product / 2^BITS, signed division truncating toward zero) << (14-BITS), then truncated to the low DATA_SIZE bits.
  - No saturation.
- Latency and throughput:
  - rd_en to wr_en is 2 cycles minimum.
  - One sample per 3 cycles; stereo frame every 6 cycles when both channels are eligible.
- Volume ramp:
  - Update on the cycle an R sample is written (r_out_wr_en=1).
  - If vol_target > vol_cur: vol_cur += min(RAMP_STEP, vol_target - vol_cur).
  - If vol_target < vol_cur: decrement symmetrically.
  - If equal: unchanged.
  - vol_cur never overshoots the target.
  - The volume used by a sample is vol_cur as of its MULT cycle. An R write and its ramp update do not affect that same R sample.
- Simultaneous events:
  - vol_target changing mid-sample has no effect until the next ramp update.
  - Both channels eligible: strict alternation.
  - An output becoming full after a grant is absorbed by the WRITE stall.

Test Plan:
- Reset, then drive vol_target=1024 and wait for the ramp to complete, with L-only traffic plus one R sample per ramp update (16 R samples). Then l_din=100 -> l_dout=1600. r_in_empty held at 1 -> r_in_rd_en never asserted.
- vol_cur=512: l_din=-3 -> product -1536 -> /1024 = -1 (truncate toward zero) -> l_dout=-16. l_din=3 -> l_dout=16.
- Both FIFOs preloaded with 4 samples each -> rd_en order L,R,L,R,L,R,L,R. Grants spaced 3 cycles apart. Never both rd_en high.
- Ramp from reset with vol_target=200, RAMP_STEP=64 -> vol_cur after successive R writes: 64, 128, 192, 200, 200. Then vol_target=0 -> 136, 72, 8, 0.
- l_out_full asserted during WRITE for 5 cycles -> l_out_wr_en stays 0, state holds, sample emitted unchanged on release. Meanwhile r_in_rd_en stays 0.
- Assert reset while in MULT -> no wr_en follows, vol_cur=0, next grant goes to L.

Source files
------------

// File: rtl/gain_scheduler_if.sv
// FIFO handshake bundle between the gain scheduler and its L/R input and output FIFOs.
// The master side is the scheduler; the slave side is the surrounding FIFOs and control.
interface gain_scheduler_if #(
    parameter int DATA_SIZE = 32
);
    logic                        l_in_empty;
    logic                        l_in_rd_en;
    logic signed [DATA_SIZE-1:0] l_din;
    logic                        r_in_empty;
    logic                        r_in_rd_en;
    logic signed [DATA_SIZE-1:0] r_din;
    logic                        l_out_full;
    logic                        l_out_wr_en;
    logic signed [DATA_SIZE-1:0] l_dout;
    logic                        r_out_full;
    logic                        r_out_wr_en;
    logic signed [DATA_SIZE-1:0] r_dout;
    logic signed [DATA_SIZE-1:0] vol_target;
    logic signed [DATA_SIZE-1:0] vol_cur;

    modport master (
        input  l_in_empty, l_din, r_in_empty, r_din,
        input  l_out_full, r_out_full, vol_target,
        output l_in_rd_en, r_in_rd_en, l_out_wr_en, l_dout,
        output r_out_wr_en, r_dout, vol_cur
    );

    modport slave (
        output l_in_empty, l_din, r_in_empty, r_din,
        output l_out_full, r_out_full, vol_target,
        input  l_in_rd_en, r_in_rd_en, l_out_wr_en, l_dout,
        input  r_out_wr_en, r_dout, vol_cur
    );
endinterface

// File: rtl/gain_scheduler.sv
// Stereo gain stage: one shared multiply/dequantize datapath, round-robin between L and R,
// with a volume register that ramps toward the software target once per R sample written.
module gain_scheduler #(
    parameter int DATA_SIZE = 32,
    parameter int BITS      = 10,
    parameter int RAMP_STEP = 64
) (
    input logic              clock,
    input logic              reset,
    gain_scheduler_if.master bus
);
    localparam int PW = 2 * DATA_SIZE;
    localparam logic signed [PW-1:0]        ROUND_BIAS = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};
    localparam logic signed [DATA_SIZE:0]   STEP_WIDE  = (DATA_SIZE+1)'(RAMP_STEP);
    localparam logic signed [DATA_SIZE-1:0] STEP       = DATA_SIZE'(RAMP_STEP);

    typedef enum logic [1:0] {ARB, MULT, WRITE} state_t;
    typedef enum logic {CH_L, CH_R} chan_t;

    state_t                      state;
    chan_t                       rr_ptr;
    chan_t                       chan;
    chan_t                       grant_chan;
    logic                        grant_valid;
    logic                        l_elig;
    logic                        r_elig;
    logic signed [DATA_SIZE-1:0] sample;
    logic signed [DATA_SIZE-1:0] vol_cur_q;
    logic signed [DATA_SIZE-1:0] vol_next;
    logic signed [DATA_SIZE-1:0] result;
    logic signed [PW-1:0]        product;
    logic signed [PW-1:0]        quotient;
    logic signed [DATA_SIZE:0]   vol_diff;

    assign l_elig = !bus.l_in_empty && !bus.l_out_full;
    assign r_elig = !bus.r_in_empty && !bus.r_out_full;

    always_comb begin
        grant_valid = l_elig || r_elig;
        if (rr_ptr == CH_L) begin
            grant_chan = l_elig ? CH_L : CH_R;
        end else begin
            grant_chan = r_elig ? CH_R : CH_L;
        end
    end

    // Biasing negative products makes the arithmetic shift truncate toward zero.
    assign quotient = (product + (product[PW-1] ? ROUND_BIAS : PW'(0))) >>> BITS;

    generate
        if (BITS <= 14) begin : g_scale_up
            assign result = DATA_SIZE'(quotient <<< (14 - BITS));
        end else begin : g_scale_down
            assign result = DATA_SIZE'(quotient >>> (BITS - 14));
        end
    endgenerate

    // One extra bit on the difference keeps the step comparison free of overflow.
    assign vol_diff = {bus.vol_target[DATA_SIZE-1], bus.vol_target}
                    - {vol_cur_q[DATA_SIZE-1], vol_cur_q};

    always_comb begin
        if (vol_diff > STEP_WIDE) begin
            vol_next = vol_cur_q + STEP;
        end else if (vol_diff < -STEP_WIDE) begin
            vol_next = vol_cur_q - STEP;
        end else begin
            vol_next = bus.vol_target;
        end
    end

    assign bus.vol_cur = vol_cur_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ARB;
            rr_ptr          <= CH_L;
            chan            <= CH_L;
            sample          <= '0;
            product         <= '0;
            vol_cur_q       <= '0;
            bus.l_in_rd_en  <= 1'b0;
            bus.r_in_rd_en  <= 1'b0;
            bus.l_out_wr_en <= 1'b0;
            bus.r_out_wr_en <= 1'b0;
            bus.l_dout      <= '0;
            bus.r_dout      <= '0;
        end else begin
            bus.l_in_rd_en  <= 1'b0;
            bus.r_in_rd_en  <= 1'b0;
            bus.l_out_wr_en <= 1'b0;
            bus.r_out_wr_en <= 1'b0;
            case (state)
                ARB: begin
                    if (grant_valid) begin
                        chan   <= grant_chan;
                        rr_ptr <= (grant_chan == CH_L) ? CH_R : CH_L;
                        state  <= MULT;
                        if (grant_chan == CH_L) begin
                            sample         <= bus.l_din;
                            bus.l_in_rd_en <= 1'b1;
                        end else begin
                            sample         <= bus.r_din;
                            bus.r_in_rd_en <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    product <= PW'(sample) * PW'(vol_cur_q);
                    state   <= WRITE;
                end
                WRITE: begin
                    if (chan == CH_L) begin
                        if (!bus.l_out_full) begin
                            bus.l_out_wr_en <= 1'b1;
                            bus.l_dout      <= result;
                            state           <= ARB;
                        end
                    end else if (!bus.r_out_full) begin
                        bus.r_out_wr_en <= 1'b1;
                        bus.r_dout      <= result;
                        vol_cur_q       <= vol_next;
                        state           <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_gain_scheduler.sv
// Randomized scoreboard bench for gain_scheduler: a FIFO/volume reference model predicts
// every output sample and the volume ramp, and a forked monitor checks each write.
module tb_gain_scheduler;
    localparam int DATA_SIZE = 32;
    localparam int BITS      = 10;
    localparam int RAMP_STEP = 64;

    typedef struct {
        bit                          chan;
        logic signed [DATA_SIZE-1:0] value;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    gain_scheduler_if #(.DATA_SIZE(DATA_SIZE)) bus ();

    gain_scheduler #(
        .DATA_SIZE(DATA_SIZE),
        .BITS(BITS),
        .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    logic signed [DATA_SIZE-1:0] lq[$];
    logic signed [DATA_SIZE-1:0] rq[$];
    logic signed [DATA_SIZE-1:0] dirVolQ[$];
    exp_t                        expQ[$];
    bit                          grantChan[$];
    int                          grantCyc[$];
    longint                      volModel;
    logic signed [DATA_SIZE-1:0] lastL;
    logic signed [DATA_SIZE-1:0] lastR;
    bit                          volCheckPending;
    int                          cycle;
    int                          rRdCount;
    int                          total;
    int                          bad;

    function automatic logic signed [DATA_SIZE-1:0] scale(longint s, longint v);
        longint q;
        q = (s * v) / (longint'(1) << BITS);
        q = q * (longint'(1) << (14 - BITS));
        return DATA_SIZE'(q);
    endfunction

    function automatic longint ramp(longint cur, longint tgt);
        if (tgt - cur > RAMP_STEP) return cur + RAMP_STEP;
        if (cur - tgt > RAMP_STEP) return cur - RAMP_STEP;
        return tgt;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit chan, input logic signed [DATA_SIZE-1:0] value);
        if (chan) rq.push_back(value);
        else      lq.push_back(value);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((lq.size() != 0 || rq.size() != 0 || expQ.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) checkOutput("drain_timeout", 1, 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic waitRd(input bit chan, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clock);
            seen = chan ? bus.r_in_rd_en : bus.l_in_rd_en;
        end
        if (!seen) checkOutput("rd_timeout", 1, 0);
    endtask

    // Plays the input FIFOs and scores every write against the reference model.
    task automatic monitor();
        exp_t                        e;
        logic signed [DATA_SIZE-1:0] s;
        forever begin
            @(negedge clock);
            cycle++;
            if (reset) begin
                expQ.delete();
                volModel        = 0;
                volCheckPending = 1'b0;
                lastL           = '0;
                lastR           = '0;
            end else begin
                if (volCheckPending) begin
                    checkOutput("vol_cur", bus.vol_cur, volModel);
                    if (dirVolQ.size() > 0) checkOutput("vol_ramp_step", bus.vol_cur, dirVolQ.pop_front());
                    volCheckPending = 1'b0;
                end
                if (bus.l_out_wr_en && bus.r_out_wr_en) checkOutput("single_wr", 1, 0);
                if (bus.l_out_wr_en) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_l_write", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("l_write_chan", 0, e.chan);
                        checkOutput("l_dout", bus.l_dout, e.value);
                        lastL = e.value;
                    end
                    checkOutput("r_dout_hold", bus.r_dout, lastR);
                end
                if (bus.r_out_wr_en) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_r_write", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("r_write_chan", 1, e.chan);
                        checkOutput("r_dout", bus.r_dout, e.value);
                        lastR = e.value;
                    end
                    checkOutput("l_dout_hold", bus.l_dout, lastL);
                    volModel        = ramp(volModel, longint'(bus.vol_target));
                    volCheckPending = 1'b1;
                end
                if (bus.l_in_rd_en && bus.r_in_rd_en) checkOutput("single_rd", 1, 0);
                if (bus.l_in_rd_en) begin
                    if (lq.size() == 0) begin
                        checkOutput("l_pop_empty", 1, 0);
                    end else begin
                        s       = lq.pop_front();
                        e.chan  = 1'b0;
                        e.value = scale(longint'(s), volModel);
                        expQ.push_back(e);
                    end
                    grantChan.push_back(1'b0);
                    grantCyc.push_back(cycle);
                end
                if (bus.r_in_rd_en) begin
                    rRdCount++;
                    if (rq.size() == 0) begin
                        checkOutput("r_pop_empty", 1, 0);
                    end else begin
                        s       = rq.pop_front();
                        e.chan  = 1'b1;
                        e.value = scale(longint'(s), volModel);
                        expQ.push_back(e);
                    end
                    grantChan.push_back(1'b1);
                    grantCyc.push_back(cycle);
                end
            end
            bus.l_in_empty = (lq.size() == 0);
            bus.l_din      = (lq.size() != 0) ? lq[0] : '0;
            bus.r_in_empty = (rq.size() == 0);
            bus.r_din      = (rq.size() != 0) ? rq[0] : '0;
        end
    endtask

    initial begin
        bit seen;
        int rBefore;
        int tgt;

        total           = 0;
        bad             = 0;
        cycle           = 0;
        rRdCount        = 0;
        volModel        = 0;
        volCheckPending = 1'b0;
        lastL           = '0;
        lastR           = '0;
        reset           = 1'b1;
        bus.l_in_empty  = 1'b1;
        bus.r_in_empty  = 1'b1;
        bus.l_din       = '0;
        bus.r_din       = '0;
        bus.l_out_full  = 1'b0;
        bus.r_out_full  = 1'b0;
        bus.vol_target  = '0;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clock);
        checkOutput("reset_l_rd", bus.l_in_rd_en, 0);
        checkOutput("reset_r_rd", bus.r_in_rd_en, 0);
        checkOutput("reset_l_wr", bus.l_out_wr_en, 0);
        checkOutput("reset_r_wr", bus.r_out_wr_en, 0);
        checkOutput("reset_l_dout", bus.l_dout, 0);
        checkOutput("reset_r_dout", bus.r_dout, 0);
        checkOutput("reset_vol_cur", bus.vol_cur, 0);
        reset = 1'b0;

        // Ramp up to 200 and back to 0, one R sample per update.
        bus.vol_target = 200;
        dirVolQ = '{64, 128, 192, 200, 200};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, $urandom);
            waitIdle(60);
        end
        checkOutput("ramp_up_steps_seen", dirVolQ.size(), 0);
        bus.vol_target = 0;
        dirVolQ = '{136, 72, 8, 0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, $urandom);
            waitIdle(60);
        end
        checkOutput("ramp_down_steps_seen", dirVolQ.size(), 0);

        // Unity volume, then a known L sample with the right channel idle.
        pulseReset();
        bus.vol_target = 1024;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, $urandom);
            applyStimulus(1'b1, $urandom);
            waitIdle(60);
        end
        checkOutput("vol_unity", bus.vol_cur, 1024);
        rBefore = rRdCount;
        applyStimulus(1'b0, 100);
        waitIdle(60);
        checkOutput("l_dout_unity", bus.l_dout, 1600);
        checkOutput("r_rd_idle", rRdCount - rBefore, 0);

        // Half volume with truncation toward zero on negative products.
        bus.vol_target = 512;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, $urandom);
        waitIdle(200);
        checkOutput("vol_half", bus.vol_cur, 512);
        applyStimulus(1'b0, -3);
        waitIdle(60);
        checkOutput("l_dout_neg_trunc", bus.l_dout, -16);
        applyStimulus(1'b0, 3);
        waitIdle(60);
        checkOutput("l_dout_pos_trunc", bus.l_dout, 16);

        // Both preloaded: strict alternation starting at L, three cycles apart.
        applyStimulus(1'b1, $urandom);
        waitIdle(60);
        grantChan.delete();
        grantCyc.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, $urandom);
            applyStimulus(1'b1, $urandom);
        end
        waitIdle(200);
        checkOutput("grant_count", grantChan.size(), 8);
        for (int i = 0; i < grantChan.size() && i < 8; i++) checkOutput("grant_order", grantChan[i], i % 2);
        for (int i = 1; i < grantCyc.size() && i < 8; i++) checkOutput("grant_spacing", grantCyc[i] - grantCyc[i-1], 3);

        // Random traffic with output back-pressure, target fixed per segment.
        for (int seg = 0; seg < 6; seg++) begin
            tgt = int'($urandom_range(8192)) - 4096;
            bus.vol_target = tgt;
            for (int c = 0; c < 80; c++) begin
                @(negedge clock);
                if ($urandom_range(3) == 0) applyStimulus(1'b0, $urandom);
                if ($urandom_range(3) == 0) applyStimulus(1'b1, $urandom);
                bus.l_out_full = ($urandom_range(3) == 0);
                bus.r_out_full = ($urandom_range(3) == 0);
            end
            bus.l_out_full = 1'b0;
            bus.r_out_full = 1'b0;
            waitIdle(1500);
        end

        bus.vol_target = 1024;
        for (int i = 0; i < 80; i++) applyStimulus(1'b1, $urandom);
        waitIdle(1000);
        checkOutput("vol_settled", bus.vol_cur, 1024);

        // Output full while the L sample sits in WRITE.
        applyStimulus(1'b0, $urandom);
        waitRd(1'b0, seen);
        if (seen) begin
            bus.l_out_full = 1'b1;
            applyStimulus(1'b1, $urandom);
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                checkOutput("stall_l_wr", bus.l_out_wr_en, 0);
                checkOutput("stall_r_rd", bus.r_in_rd_en, 0);
            end
        end
        bus.l_out_full = 1'b0;
        waitIdle(100);

        // Reset while the sample is in MULT: it must vanish.
        applyStimulus(1'b0, $urandom);
        waitRd(1'b0, seen);
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkOutput("post_reset_no_wr", bus.l_out_wr_en | bus.r_out_wr_en, 0);
        end
        checkOutput("post_reset_vol", bus.vol_cur, 0);
        applyStimulus(1'b1, $urandom);
        applyStimulus(1'b0, $urandom);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clock);
            seen = bus.l_in_rd_en | bus.r_in_rd_en;
        end
        checkOutput("post_reset_grant_seen", seen, 1);
        checkOutput("post_reset_grant_is_l", bus.l_in_rd_en, 1);
        waitIdle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
